mips_mc_control: RTL and testbench

Multicycle sequencing controller for the MIPS datapath. It steps each instruction through fetch, decode, execute, memory and writeback. Instruction and data accesses share a single memory port, arbitrated by the state machine. The block consumes the combinational outputs of `mips_decode`, driven from the instruction register, and produces gated write strobes, memory handshake signals and mux selects. It also counts retired instructions and halts on an exception or a memory timeout.

---
 rtl/mips_mc_if.sv | 23 ++
 rtl/mips_mc_control.sv | 194 +++++++++++++++++++
 tb/tb_mips_mc_control.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_mc_if.sv
// Shared memory-port handshake between the multicycle controller and memory.
// The controller is the master: it raises a request and selects the address
// source; memory answers with mem_ready in the same cycle it completes.
interface mips_mc_if;
    logic mem_req;       // memory request
    logic mem_we;        // request is a write
    logic mem_addr_sel;  // 0: PC, 1: ALU result
    logic mem_ready;     // acknowledge, completes the transfer this cycle

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr_sel,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr_sel,
        output mem_ready
    );
endinterface

// File: rtl/mips_mc_control.sv
// Multicycle sequencing controller for the MIPS datapath.
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB, arbitrates
// the single memory port, gates the datapath write strobes, counts retired
// instructions and stops in HALT on an illegal instruction or a memory timeout.
// Outputs are combinational from the state register and the inputs; every
// strobe is held low while reset is high so an interrupted instruction leaves
// no trace.
module mips_mc_control #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             writeenable,
    input  logic             except,
    input  logic [1:0]       control_type,
    input  logic             mem_read,
    input  logic             word_we,
    input  logic             byte_we,
    input  logic             addm,
    mips_mc_if.master        mem,
    output logic             ir_we,
    output logic             mdr_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic             addm_sel,
    output logic             halted,
    output logic             bus_error,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [WAIT_W-1:0]  wait_cnt_r;
    logic [CNT_W-1:0]   retired_r;
    logic               halted_r;
    logic               bus_error_r;

    logic               mem_req_s;
    logic               mem_we_s;
    logic               mem_addr_sel_s;
    logic               ir_we_s;
    logic               mdr_we_s;
    logic               rf_we_s;
    logic               pc_we_s;
    logic               addm_sel_s;
    logic               at_limit_s;
    logic               timeout_s;
    logic               mem_op_s;
    logic               store_s;

    // The decoder never flags a memory class on a branch or jump, so a
    // control transfer always takes the single-cycle ALU path.
    assign mem_op_s   = (control_type == 2'd0) & (mem_read | word_we | byte_we | addm);
    assign store_s    = word_we | byte_we;
    // The current cycle is the last wait the request is allowed.
    assign at_limit_s = (wait_cnt_r == WAIT_W'(MEM_TIMEOUT - 1));
    assign timeout_s  = mem_req_s & ~mem.mem_ready & at_limit_s;

    // Next-state and strobe decode from the current state and decoder flags.
    always_comb begin
        state_next_s   = state_r;
        mem_req_s      = 1'b0;
        mem_we_s       = 1'b0;
        mem_addr_sel_s = 1'b0;
        ir_we_s        = 1'b0;
        mdr_we_s       = 1'b0;
        rf_we_s        = 1'b0;
        pc_we_s        = 1'b0;
        addm_sel_s     = 1'b0;
        case (state_r)
            ST_FETCH: begin
                mem_req_s = 1'b1;
                if (mem.mem_ready) begin
                    ir_we_s      = 1'b1;
                    state_next_s = ST_DECODE;
                end else if (at_limit_s) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (except) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (mem_op_s) begin
                    state_next_s = ST_MEM;
                end else begin
                    rf_we_s      = writeenable;
                    pc_we_s      = 1'b1;
                    state_next_s = ST_FETCH;
                end
            end
            ST_MEM: begin
                mem_req_s      = 1'b1;
                mem_addr_sel_s = 1'b1;
                mem_we_s       = store_s;
                if (mem.mem_ready) begin
                    if (store_s) begin
                        pc_we_s      = 1'b1;
                        state_next_s = ST_FETCH;
                    end else begin
                        mdr_we_s     = 1'b1;
                        state_next_s = ST_WB;
                    end
                end else if (at_limit_s) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_MEM;
                end
            end
            ST_WB: begin
                rf_we_s      = writeenable;
                addm_sel_s   = addm;
                pc_we_s      = 1'b1;
                state_next_s = ST_FETCH;
            end
            ST_HALT: begin
                state_next_s = ST_HALT;
            end
            default: begin
                state_next_s = ST_HALT;
            end
        endcase
    end

    // State, wait counter, retired counter and sticky halt/error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_FETCH;
            wait_cnt_r  <= '0;
            retired_r   <= '0;
            halted_r    <= 1'b0;
            bus_error_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            // Any cycle without an outstanding wait clears the counter, so it
            // is always zero on entry to FETCH or MEM.
            if (mem_req_s && !mem.mem_ready) begin
                wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
            end else begin
                wait_cnt_r <= '0;
            end
            if (pc_we_s) begin
                retired_r <= retired_r + CNT_W'(1);
            end else begin
                retired_r <= retired_r;
            end
            if (state_next_s == ST_HALT) begin
                halted_r <= 1'b1;
            end else begin
                halted_r <= halted_r;
            end
            if (timeout_s) begin
                bus_error_r <= 1'b1;
            end else begin
                bus_error_r <= bus_error_r;
            end
        end
    end

    // Strobes are suppressed while reset is asserted.
    assign mem.mem_req      = mem_req_s      & ~reset;
    assign mem.mem_we       = mem_we_s       & ~reset;
    assign mem.mem_addr_sel = mem_addr_sel_s & ~reset;
    assign ir_we            = ir_we_s        & ~reset;
    assign mdr_we           = mdr_we_s       & ~reset;
    assign rf_we            = rf_we_s        & ~reset;
    assign pc_we            = pc_we_s        & ~reset;
    assign addm_sel         = addm_sel_s     & ~reset;

    assign halted    = halted_r;
    assign bus_error = bus_error_r;
    assign state     = state_r;
    assign retired   = retired_r;

endmodule

// File: tb/tb_mips_mc_control.sv
// Scoreboard bench for mips_mc_control. The stimulus process drives one
// cycle of inputs at a time and pushes the hand-computed output vector for
// that cycle; an independent monitor pops and compares on the falling edge.
// Strobe vector bit order: {mem_req, mem_we, mem_addr_sel, ir_we, mdr_we,
//                           rf_we, pc_we, addm_sel, halted, bus_error}
module tb_mips_mc_control;

    logic       clk = 1'b0;
    logic       reset;
    logic       writeenable, except, mem_read, word_we, byte_we, addm;
    logic [1:0] control_type;
    logic       ir_we, mdr_we, rf_we, pc_we, addm_sel, halted, bus_error;
    logic [2:0] state;
    logic [7:0] retired;

    mips_mc_if mif();

    mips_mc_control #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .writeenable  (writeenable),
        .except       (except),
        .control_type (control_type),
        .mem_read     (mem_read),
        .word_we      (word_we),
        .byte_we      (byte_we),
        .addm         (addm),
        .mem          (mif),
        .ir_we        (ir_we),
        .mdr_we       (mdr_we),
        .rf_we        (rf_we),
        .pc_we        (pc_we),
        .addm_sel     (addm_sel),
        .halted       (halted),
        .bus_error    (bus_error),
        .state        (state),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    logic [20:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc_no = 0;
    string       phase = "init";

    // Monitor: compare every scheduled cycle against the scoreboard head.
    always @(negedge clk) begin
        logic [20:0] e;
        logic [20:0] g;
        cyc_no = cyc_no + 1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            g = {state, mif.mem_req, mif.mem_we, mif.mem_addr_sel, ir_we, mdr_we,
                 rf_we, pc_we, addm_sel, halted, bus_error, retired};
            n_cmp = n_cmp + 1;
            if (g !== e) begin
                n_err = n_err + 1;
                $display("FAIL %s @cycle %0d: got state=%0d strobes=%b retired=%0d, expected state=%0d strobes=%b retired=%0d",
                         phase, cyc_no, g[20:18], g[17:8], g[7:0], e[20:18], e[17:8], e[7:0]);
            end
        end
    end

    task automatic set_dec(input logic we, input logic exc, input logic [1:0] ct,
                           input logic rd, input logic wwe, input logic bwe, input logic am);
        writeenable  = we;
        except       = exc;
        control_type = ct;
        mem_read     = rd;
        word_we      = wwe;
        byte_we      = bwe;
        addm         = am;
    endtask

    // One clock cycle: apply inputs, schedule the expected outputs, advance.
    task automatic cyc(input logic r, input logic rdy, input logic [2:0] st,
                       input logic [9:0] sb, input logic [7:0] ret);
        reset         = r;
        mif.mem_ready = rdy;
        exp_q.push_back({st, sb, ret});
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        mif.mem_ready = 1'b0;
        set_dec(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Reset state: FETCH, no strobes (mem_req forced low), counters clear.
        phase = "reset";
        cyc(1'b1, 1'b1, 3'd0, 10'b0000000000, 8'd0);

        // add, zero-wait: 0 -> 1 -> 2 -> 0, retire in EXEC.
        phase = "add";
        set_dec(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 3'd0, 10'b1001000000, 8'd0);
        cyc(1'b0, 1'b1, 3'd1, 10'b0000000000, 8'd0);
        cyc(1'b0, 1'b1, 3'd2, 10'b0000011000, 8'd0);

        // beq (control transfer, no register write): pc_we only.
        phase = "beq";
        set_dec(1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 3'd0, 10'b1001000000, 8'd1);
        cyc(1'b0, 1'b1, 3'd1, 10'b0000000000, 8'd1);
        cyc(1'b0, 1'b1, 3'd2, 10'b0000001000, 8'd1);

        // lw: 2 waits in FETCH, 1 wait in MEM; retire in WB on cycle 8.
        phase = "lw";
        set_dec(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 3'd0, 10'b1000000000, 8'd2);
        cyc(1'b0, 1'b0, 3'd0, 10'b1000000000, 8'd2);
        cyc(1'b0, 1'b1, 3'd0, 10'b1001000000, 8'd2);
        cyc(1'b0, 1'b1, 3'd1, 10'b0000000000, 8'd2);
        cyc(1'b0, 1'b1, 3'd2, 10'b0000000000, 8'd2);
        cyc(1'b0, 1'b0, 3'd3, 10'b1010000000, 8'd2);
        cyc(1'b0, 1'b1, 3'd3, 10'b1010100000, 8'd2);
        cyc(1'b0, 1'b0, 3'd4, 10'b0000011000, 8'd2);

        // sw: write in MEM, retire there, no WB and no rf_we.
        phase = "sw";
        set_dec(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 3'd0, 10'b1001000000, 8'd3);
        cyc(1'b0, 1'b1, 3'd1, 10'b0000000000, 8'd3);
        cyc(1'b0, 1'b1, 3'd2, 10'b0000000000, 8'd3);
        cyc(1'b0, 1'b1, 3'd3, 10'b1110001000, 8'd3);

        // addm: read in MEM, second add selects MDR in WB.
        phase = "addm";
        set_dec(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 3'd0, 10'b1001000000, 8'd4);
        cyc(1'b0, 1'b1, 3'd1, 10'b0000000000, 8'd4);
        cyc(1'b0, 1'b1, 3'd2, 10'b0000000000, 8'd4);
        cyc(1'b0, 1'b1, 3'd3, 10'b1010100000, 8'd4);
        cyc(1'b0, 1'b1, 3'd4, 10'b0000011100, 8'd4);

        // Illegal instruction: HALT for 20 cycles, mem_ready ignored.
        phase = "except";
        set_dec(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 3'd0, 10'b1001000000, 8'd5);
        cyc(1'b0, 1'b1, 3'd1, 10'b0000000000, 8'd5);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'(i % 2), 3'd5, 10'b0000000010, 8'd5);
        end
        cyc(1'b1, 1'b0, 3'd5, 10'b0000000010, 8'd5);

        // Fetch timeout at MEM_TIMEOUT=4; first post-reset cycle is wait #1.
        phase = "timeout";
        set_dec(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 3'd0, 10'b1000000000, 8'd0);
        end
        cyc(1'b0, 1'b1, 3'd5, 10'b0000000011, 8'd0);
        cyc(1'b0, 1'b0, 3'd5, 10'b0000000011, 8'd0);
        cyc(1'b1, 1'b0, 3'd5, 10'b0000000011, 8'd0);

        // Acknowledge on the 4th wait cycle wins over the timeout.
        phase = "ack_at_limit";
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 3'd0, 10'b1000000000, 8'd0);
        end
        cyc(1'b0, 1'b1, 3'd0, 10'b1001000000, 8'd0);
        cyc(1'b0, 1'b0, 3'd1, 10'b0000000000, 8'd0);
        cyc(1'b0, 1'b0, 3'd2, 10'b0000001000, 8'd0);

        // Reset mid-load in MEM: strobes suppressed, back to FETCH, count cleared.
        phase = "reset_in_mem";
        set_dec(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 3'd0, 10'b1001000000, 8'd1);
        cyc(1'b0, 1'b1, 3'd1, 10'b0000000000, 8'd1);
        cyc(1'b0, 1'b1, 3'd2, 10'b0000000000, 8'd1);
        cyc(1'b0, 1'b0, 3'd3, 10'b1010000000, 8'd1);
        cyc(1'b1, 1'b1, 3'd3, 10'b0000000000, 8'd1);
        cyc(1'b0, 1'b0, 3'd0, 10'b1000000000, 8'd0);
        cyc(1'b1, 1'b0, 3'd0, 10'b0000000000, 8'd0);

        // 256 adds: the 8-bit retired counter wraps back to 0.
        phase = "wrap";
        set_dec(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) begin
            cyc(1'b0, 1'b1, 3'd0, 10'b1001000000, 8'(i));
            cyc(1'b0, 1'b1, 3'd1, 10'b0000000000, 8'(i));
            cyc(1'b0, 1'b1, 3'd2, 10'b0000011000, 8'(i));
        end
        cyc(1'b0, 1'b0, 3'd0, 10'b1000000000, 8'd0);

        // Drain the scoreboard with a bounded wait.
        phase = "drain";
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            n_err = n_err + 1;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
